// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Four-digit time-multiplexed seven-segment scan driver.
//               One digit per SCAN_DIV-cycle slot, a BLANK_CYC-cycle anode
//               blanking gap at the start of every slot, and a shadow
//               (pending) register so new values only reach the display at
//               frame boundaries.
//               Optional feature macro: SEG_SCAN_LZB_EN (leading-zero
//               blanking of digits 3..1).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        frame_tick,
  output logic [3:0]  anode,
  output logic [7:0]  segment
);

  localparam int                  c_CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_disp;
  logic [3:0]         r_dp;
  logic [15:0]        r_pend;
  logic [3:0]         r_pend_dp;
  logic               r_pend_v;

  logic               w_cnt_wrap;
  logic               w_boundary;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]         w_idx_nxt;
  logic [15:0]        w_disp_nxt;
  logic [3:0]         w_dp_nxt;
  logic               w_in_blank;
  logic [3:0]         w_nib;
  logic               w_dp_sel;
  logic [7:0]         w_seg_nxt;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  assign w_cnt_wrap = (r_cnt == c_CNT_MAX);
  assign w_boundary = w_cnt_wrap && (r_idx == 2'd3);
  assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt  = w_cnt_wrap ? r_idx + 2'd1 : r_idx;

  // The display only changes on the frame boundary, and only from the value
  // pending before that edge; a load on the same edge waits a frame.
  assign w_disp_nxt = (w_boundary && r_pend_v) ? r_pend    : r_disp;
  assign w_dp_nxt   = (w_boundary && r_pend_v) ? r_pend_dp : r_dp;

  // Outputs are registered from next-state values so they line up with the
  // counters they describe in the same cycle.
  generate
    if (BLANK_CYC == 0) begin : g_blank_none
      assign w_in_blank = 1'b0;
    end else begin : g_blank_gap
      localparam logic [c_CNT_W-1:0] c_BLANK = c_CNT_W'(BLANK_CYC);
      assign w_in_blank = (w_cnt_nxt < c_BLANK);
    end
  endgenerate

  // Select the nibble and decimal point of the digit being scanned next.
  always_comb begin
    w_nib = 4'h0;
    case (w_idx_nxt)
      2'd0:    w_nib = w_disp_nxt[3:0];
      2'd1:    w_nib = w_disp_nxt[7:4];
      2'd2:    w_nib = w_disp_nxt[11:8];
      default: w_nib = w_disp_nxt[15:12];
    endcase
    w_dp_sel = w_dp_nxt[w_idx_nxt];
  end

`ifdef SEG_SCAN_LZB_EN
  logic w_lz_blank;

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows, and a lit decimal point keeps the digit visible.
  always_comb begin
    w_lz_blank = 1'b0;
    case (w_idx_nxt)
      2'd3:    w_lz_blank = (w_disp_nxt[15:12] == 4'h0);
      2'd2:    w_lz_blank = (w_disp_nxt[15:8]  == 8'h00);
      2'd1:    w_lz_blank = (w_disp_nxt[15:4]  == 12'h000);
      default: w_lz_blank = 1'b0;
    endcase
    w_seg_nxt = (w_lz_blank && !w_dp_sel) ? 8'hFF : {~w_dp_sel, seg7(w_nib)};
  end
`else
  assign w_seg_nxt = {~w_dp_sel, seg7(w_nib)};
`endif

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Pending shadow register: last load wins, cleared once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= 16'h0000;
      r_pend_dp <= 4'h0;
      r_pend_v  <= 1'b0;
    end else if (load) begin
      r_pend    <= value;
      r_pend_dp <= dp_in;
      r_pend_v  <= 1'b1;
    end else if (w_boundary) begin
      r_pend_v  <= 1'b0;
    end
  end

  // Display register, updated only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= 16'h0000;
      r_dp   <= 4'h0;
    end else begin
      r_disp <= w_disp_nxt;
      r_dp   <= w_dp_nxt;
    end
  end

  // Registered display outputs and frame start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode      <= 4'b1111;
      segment    <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      anode      <= w_in_blank ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
      segment    <= w_seg_nxt;
      frame_tick <= (w_idx_nxt == 2'd0) && (w_cnt_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan
// Description : Self-checking bench for seg_scan (SCAN_DIV=8, BLANK_CYC=2)
//               with a cycle-count based reference model and directed
//               literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        frame_tick;
  logic [3:0]  anode;
  logic [7:0]  segment;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .frame_tick(frame_tick), .anode(anode), .segment(segment)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the number of edges since reset.
  int          m_t;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  bit          m_pv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_pend <= 16'h0; m_disp <= 16'h0; m_pdp <= 4'h0; m_ddp <= 4'h0; m_pv <= 1'b0;
    end else begin
      if ((m_t % FR) == FR - 1 && m_pv) begin
        m_disp <= m_pend;
        m_ddp  <= m_pdp;
      end
      if (load) begin
        m_pend <= value; m_pdp <= dp_in; m_pv <= 1'b1;
      end else if ((m_t % FR) == FR - 1) begin
        m_pv <= 1'b0;
      end
      m_t <= m_t + 1;
    end
  end

  function automatic logic [7:0] exp_seg(int tt, logic [15:0] d, logic [3:0] p);
    int          i;
    logic [15:0] up;
    logic [7:0]  s;
    if (tt == 0) return 8'hFF;
    i  = (tt / SD) % 4;
    up = d >> (4 * i);
    s  = {~p[i], PAT[up[3:0]]};
`ifdef SEG_SCAN_LZB_EN
    if (i > 0 && up == 16'h0 && !p[i]) s = 8'hFF;
`endif
    return s;
  endfunction

  function automatic logic [3:0] exp_anode(int tt);
    logic [3:0] one;
    logic [3:0] a;
    one = 4'b0001;
    if (tt == 0 || (tt % SD) < BC) a = 4'b1111;
    else a = ~(one << ((tt / SD) % 4));
    return a;
  endfunction

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ea;
      logic [7:0] es;
      logic       et;
      ea = exp_anode(m_t);
      es = exp_seg(m_t, m_disp, m_ddp);
      et = (m_t > 0) && ((m_t % FR) == 0);
      n_checks += 3;
      if (anode !== ea) begin
        n_fail++; $display("FAIL model_anode t=%0d got %b exp %b", m_t, anode, ea);
      end
      if (segment !== es) begin
        n_fail++; $display("FAIL model_segment t=%0d got %h exp %h", m_t, segment, es);
      end
      if (frame_tick !== et) begin
        n_fail++; $display("FAIL model_frame_tick t=%0d got %b exp %b", m_t, frame_tick, et);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frame_tick", {7'h0, frame_tick}, 8'h01);
  endtask

  task automatic check_digit(input int d, input logic [7:0] e, input string nm);
    int         k;
    logic [3:0] one;
    logic [3:0] want;
    one  = 4'b0001;
    want = ~(one << d);
    k    = 0;
    while (anode !== want && k < 2 * FR) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_anode"}, {4'h0, anode}, {4'h0, want});
    chk(nm, segment, e);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value = v; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_anode", {4'h0, anode}, 8'h0F);
    chk("reset_segment", segment, 8'hFF);
    chk("reset_tick", {7'h0, frame_tick}, 8'h00);
    rst_n = 1'b1;

    // Free run after release.
    @(negedge clk);
    chk("edge1_anode", {4'h0, anode}, 8'h0F);
    @(negedge clk);
    chk("edge2_anode", {4'h0, anode}, 8'h0E);
    chk("edge2_segment", segment, 8'hC0);
    repeat (29) @(negedge clk);
    chk("edge31_no_tick", {7'h0, frame_tick}, 8'h00);
    @(negedge clk);
    chk("edge32_tick", {7'h0, frame_tick}, 8'h01);

    // Mid-frame load shows from the next frame.
    repeat (5) @(negedge clk);
    do_load(16'h1A8F, 4'b0100);
    check_digit(3, 8'hC0, "midframe_old_digit3");
    wait_tick();
    check_digit(0, 8'h8E, "load_digit0");
    check_digit(1, 8'h80, "load_digit1");
    check_digit(2, 8'h08, "load_digit2");
    check_digit(3, 8'hF9, "load_digit3");

    // Load on the boundary cycle waits one extra frame.
    wait_tick();
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'h0);
    while ((m_t % FR) != FR - 1) @(negedge clk);
    do_load(16'h3333, 4'h0);
    check_digit(0, 8'hA4, "boundary_old_pending");
    wait_tick();
    check_digit(0, 8'hB0, "boundary_new_value");

    // Two loads in a frame: last one wins.
    repeat (4) @(negedge clk);
    do_load(16'h5555, 4'h0);
    @(negedge clk);
    do_load(16'h6666, 4'h1);
    wait_tick();
    check_digit(0, 8'h02, "two_loads_digit0");
    check_digit(1, 8'h82, "two_loads_digit1");

    // Asynchronous reset mid-slot drops the pending load.
    do_load(16'h7777, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_anode", {4'h0, anode}, 8'h0F);
    chk("async_rst_segment", segment, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_segment", segment, 8'hC0);
    wait_tick();
    check_digit(0, 8'hC0, "pending_lost_digit0");

    // Leading-zero case.
    do_load(16'h0040, 4'h0);
    wait_tick();
    check_digit(0, 8'hC0, "lz_digit0");
    check_digit(1, 8'h99, "lz_digit1");
`ifdef SEG_SCAN_LZB_EN
    check_digit(2, 8'hFF, "lz_digit2");
    check_digit(3, 8'hFF, "lz_digit3");
`else
    check_digit(2, 8'hC0, "lz_digit2");
    check_digit(3, 8'hC0, "lz_digit3");
`endif

    // Randomized loads and occasional resets, checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      load  = ($urandom_range(0, 15) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
    end
    load = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
